// File: rtl/hook_ctrl.sv
// Fishing-hook controller: drives the hook sprite row and mode, manages the bait stock,
// and pulses catch_pulse when a reeled-in fish reaches the surface.
module hook_ctrl #(
  parameter int unsigned TOP_V     = 62,
  parameter int unsigned BOTTOM_V  = 460,
  parameter int unsigned STEP      = 2,
  parameter int unsigned REEL_STEP = 4,
  parameter int unsigned BAIT_INIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] mouse_y,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       bite,
  input  logic       refill,
  output logic [1:0] mode,
  output logic [9:0] hook_v,
  output logic [3:0] bait_cnt,
  output logic       catch_pulse
);

  localparam logic [9:0] TOP_R    = 10'(TOP_V);
  localparam logic [9:0] BOTTOM_R = 10'(BOTTOM_V);
  localparam logic [9:0] STEP_R   = 10'(STEP);
  localparam logic [9:0] REEL_R   = 10'(REEL_STEP);
  localparam logic [3:0] BAIT_R   = 4'(BAIT_INIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOOK   = 2'd1,
    S_BAITED = 2'd2,
    S_REEL   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] hook_q, hook_d;
  logic [3:0] bait_q, bait_d;
  logic       catch_q, catch_d;
  logic       btn_l_q, btn_r_q;
  logic       l_edge, r_edge;
  logic       bait_take;
  logic [9:0] target;

  function automatic logic [9:0] clamp_row(input logic [9:0] y);
    if (y < TOP_R)    return TOP_R;
    if (y > BOTTOM_R) return BOTTOM_R;
    return y;
  endfunction

  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > STEP_R) ? cur + STEP_R : tgt;
    end
    diff = cur - tgt;
    return (diff > STEP_R) ? cur - STEP_R : tgt;
  endfunction

  function automatic logic [9:0] reel_up(input logic [9:0] cur);
    return (cur < TOP_R + REEL_R) ? TOP_R : cur - REEL_R;
  endfunction

  // take is only ever asserted with a non-zero count, so the subtraction cannot wrap
  function automatic logic [3:0] bait_update(input logic [3:0] cnt, input logic add,
                                             input logic take);
    logic [4:0] s;
    s = {1'b0, cnt};
    if (add)  s = s + 5'd5;
    if (take) s = s - 5'd1;
    return (s > 5'd15) ? 4'd15 : s[3:0];
  endfunction

  assign l_edge = btn_left  & ~btn_l_q;
  assign r_edge = btn_right & ~btn_r_q;
  assign target = clamp_row(mouse_y);

  always_comb begin
    state_d   = state_q;
    hook_d    = hook_q;
    catch_d   = 1'b0;
    bait_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        hook_d = TOP_R;
        if (l_edge) state_d = S_HOOK;
      end
      S_HOOK: begin
        if (frame_tick) hook_d = step_toward(hook_q, target);
        if (l_edge && (hook_q == TOP_R) && (bait_q != 4'd0)) begin
          state_d   = S_BAITED;
          bait_take = 1'b1;
        end
      end
      S_BAITED: begin
        // a bite on a frame tick outranks a simultaneous discard
        if (bite && frame_tick) begin
          state_d = S_REEL;
        end else begin
          if (frame_tick) hook_d = step_toward(hook_q, target);
          if (r_edge) state_d = S_HOOK;
        end
      end
      S_REEL: begin
        if (hook_q == TOP_R) begin
          state_d = S_HOOK;
          catch_d = 1'b1;
        end else if (frame_tick) begin
          hook_d = reel_up(hook_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    bait_d = bait_update(bait_q, refill, bait_take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hook_q  <= TOP_R;
      bait_q  <= BAIT_R;
      catch_q <= 1'b0;
      btn_l_q <= 1'b0;
      btn_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hook_q  <= hook_d;
      bait_q  <= bait_d;
      catch_q <= catch_d;
      btn_l_q <= btn_left;
      btn_r_q <= btn_right;
    end
  end

  assign mode        = state_q;
  assign hook_v      = hook_q;
  assign bait_cnt    = bait_q;
  assign catch_pulse = catch_q;

endmodule

// File: tb/tb_hook_ctrl.sv
// Bench for hook_ctrl: vector table, directed multi-cycle sequences, and randomized
// traffic compared every cycle against an integer rule model.
module tb_hook_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, btn_left, btn_right, bite, refill;
  logic [9:0] mouse_y;
  logic [1:0] mode;
  logic [9:0] hook_v;
  logic [3:0] bait_cnt;
  logic       catch_pulse;

  int checks = 0;
  int errors = 0;

  // rule-model state
  int m_mode, m_hook, m_bait, m_catch, m_pl, m_pr;

  hook_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_y(mouse_y),
    .btn_left(btn_left), .btn_right(btn_right), .bite(bite), .refill(refill),
    .mode(mode), .hook_v(hook_v), .bait_cnt(bait_cnt), .catch_pulse(catch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fr; int my; bit bl; bit br; bit bt; bit rf;
    int e_mode; int e_hook; int e_bait; int e_catch;
  } vec_t;

  function automatic void model_step();
    int le, re, tgt, take, old_mode, delta, attach;
    if (rst) begin
      m_mode = 0; m_hook = 62; m_bait = 3; m_catch = 0; m_pl = 0; m_pr = 0;
      return;
    end
    le = (btn_left && !m_pl) ? 1 : 0;
    re = (btn_right && !m_pr) ? 1 : 0;
    m_pl = btn_left; m_pr = btn_right;
    tgt = int'(mouse_y);
    if (tgt < 62) tgt = 62;
    if (tgt > 460) tgt = 460;
    take = 0; m_catch = 0; old_mode = m_mode;
    if (old_mode == 0) begin
      if (le) m_mode = 1;
    end else if (old_mode == 3) begin
      if (m_hook == 62) begin m_catch = 1; m_mode = 1; end
      else if (frame_tick) m_hook = (m_hook - 4 < 62) ? 62 : m_hook - 4;
    end else if (old_mode == 2 && frame_tick && bite) begin
      m_mode = 3;
    end else begin
      attach = (old_mode == 1 && le && m_hook == 62 && m_bait > 0) ? 1 : 0;
      if (frame_tick) begin
        delta = tgt - m_hook;
        if (delta > 2) delta = 2;
        if (delta < -2) delta = -2;
        m_hook = m_hook + delta;
      end
      if (attach) begin m_mode = 2; take = 1; end
      else if (old_mode == 2 && re) m_mode = 1;
    end
    m_bait = m_bait + (refill ? 5 : 0) - take;
    if (m_bait > 15) m_bait = 15;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int em, input int eh, input int eb, input int ec);
    chk({tag, ".mode"}, int'(mode), em);
    chk({tag, ".hook_v"}, int'(hook_v), eh);
    chk({tag, ".bait_cnt"}, int'(bait_cnt), eb);
    chk({tag, ".catch"}, int'(catch_pulse), ec);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 0; frame_tick = 0; btn_left = 0; btn_right = 0; bite = 0; refill = 0;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1;
    for (int i = 0; i < n; i++) step();
    frame_tick = 0;
  endtask

  task automatic press_left();
    btn_left = 1; step(); btn_left = 0; step();
  endtask

  task automatic press_right();
    btn_right = 1; step(); btn_right = 0; step();
  endtask

  task automatic do_reset();
    clear_in(); rst = 1; step(); rst = 0;
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{0,   0, 1, 0, 0, 0, 1, 62, 3, 0};
    vt[1]  = '{0,   0, 1, 0, 0, 0, 1, 62, 3, 0};
    vt[2]  = '{0,   0, 0, 0, 0, 0, 1, 62, 3, 0};
    vt[3]  = '{0,   0, 1, 0, 0, 0, 2, 62, 2, 0};
    vt[4]  = '{1, 100, 0, 0, 0, 0, 2, 64, 2, 0};
    vt[5]  = '{0, 100, 0, 0, 1, 0, 2, 64, 2, 0};
    vt[6]  = '{1,   0, 0, 0, 0, 0, 2, 62, 2, 0};
    vt[7]  = '{1,   0, 0, 0, 0, 0, 2, 62, 2, 0};
    vt[8]  = '{0,   0, 0, 1, 0, 0, 1, 62, 2, 0};
    vt[9]  = '{0,   0, 0, 0, 0, 1, 1, 62, 7, 0};
    vt[10] = '{0,   0, 1, 0, 0, 1, 2, 62, 11, 0};
    vt[11] = '{1,   0, 0, 1, 1, 0, 3, 62, 11, 0};
    vt[12] = '{0,   0, 0, 0, 0, 0, 1, 62, 11, 1};
    vt[13] = '{0,   0, 0, 0, 0, 0, 1, 62, 11, 0};

    mouse_y = 0;
    do_reset();
    chk_all("reset", 0, 62, 3, 0);

    foreach (vt[i]) begin
      frame_tick = vt[i].fr; mouse_y = 10'(vt[i].my); btn_left = vt[i].bl;
      btn_right = vt[i].br; bite = vt[i].bt; refill = vt[i].rf;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_mode, vt[i].e_hook, vt[i].e_bait, vt[i].e_catch);
    end
    clear_in();

    // bait, descend to 100, bite, reel to the surface
    press_left();
    chk_all("attach", 2, 62, 10, 0);
    mouse_y = 100; ticks(19);
    chk_all("descend100", 2, 100, 10, 0);
    bite = 1; frame_tick = 1; step(); bite = 0; frame_tick = 0;
    chk_all("bite", 3, 100, 10, 0);
    ticks(9);
    chk_all("reel9", 3, 64, 10, 0);
    ticks(1);
    chk_all("reel10", 3, 62, 10, 0);
    step();
    chk_all("landed", 1, 62, 10, 1);
    step();
    chk_all("after_land", 1, 62, 10, 0);

    // empty stock, ignored attach, refill saturation
    do_reset();
    press_left();
    for (int i = 0; i < 3; i++) begin press_left(); press_right(); end
    chk_all("drained", 1, 62, 0, 0);
    press_left();
    chk_all("no_bait", 1, 62, 0, 0);
    refill = 1; step(); step(); step(); step(); refill = 0;
    chk_all("refill_sat", 1, 62, 15, 0);

    // bottom clamp, discard, attach away from surface
    press_left();
    mouse_y = 1000; ticks(300);
    chk_all("bottom", 2, 460, 14, 0);
    mouse_y = 1023; ticks(3);
    chk_all("bottom1023", 2, 460, 14, 0);
    press_right();
    chk_all("discard", 1, 460, 14, 0);
    press_left();
    chk_all("deep_attach", 1, 460, 14, 0);

    // reset during reeling
    mouse_y = 0; ticks(200);
    chk_all("surface", 1, 62, 14, 0);
    press_left();
    mouse_y = 200; ticks(69);
    chk_all("at200", 2, 200, 13, 0);
    bite = 1; frame_tick = 1; step(); bite = 0; frame_tick = 0;
    chk_all("reel200", 3, 200, 13, 0);
    rst = 1; frame_tick = 1; btn_left = 1; refill = 1; step();
    clear_in();
    chk_all("rst_reel", 0, 62, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_catch_after_rst", int'(catch_pulse), 0);
    end

    // randomized traffic against the rule model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
      bite       = ($urandom_range(0, 3) == 0);
      refill     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: mouse_y = 10'd0;
          1: mouse_y = 10'd1023;
          default: mouse_y = 10'($urandom_range(0, 1023));
        endcase
      end
      step();
      chk_all("rand", m_mode, m_hook, m_bait, m_catch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
